// File: rtl/singles_byte_serializer.sv
// Serializes FWFT fifo words MSB-first onto the GigEx TX byte bus; byte 0 valid the cycle after accept,
// one byte per cycle; stalls one cycle after the selected channel's full flag and never drops or repeats.
module singles_byte_serializer #(
   parameter int WIDTH     = 128,
   parameter int NCHAN     = 8,
   parameter int CHANNEL   = 0,
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 valid,
   output logic                 ready,
   input  logic [WIDTH-1:0]     data,
   input  logic [NCHAN-1:0]     channel_full,
   output logic [7:0]           byte_out,
   output logic                 byte_out_valid,
   output logic [2:0]           channel,
   output logic [CNT_WIDTH-1:0] words_sent
);

   localparam int BYTES = WIDTH / 8;
   localparam int CW    = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam logic [CW-1:0] LAST = CW'(BYTES - 1);

   typedef enum logic {IDLE, SEND} state_t;

   state_t               state, state_nxt;
   logic [WIDTH-1:0]     shift_q, shift_nxt;
   logic [CW-1:0]        cnt_q, cnt_nxt;
   logic                 full_q;
   logic [CNT_WIDTH-1:0] ws_nxt;
   logic                 take;
   logic                 unused_full;

   // Only the singles channel's flag matters; the rest are deliberately ignored.
   assign unused_full = ^channel_full;

   assign channel  = 3'(CHANNEL);
   assign byte_out = shift_q[WIDTH-1 -: 8];
   assign ready    = take & rst_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         shift_q    <= '0;
         cnt_q      <= '0;
         full_q     <= 1'b1;
         words_sent <= '0;
      end else begin
         state      <= state_nxt;
         shift_q    <= shift_nxt;
         cnt_q      <= cnt_nxt;
         full_q     <= channel_full[CHANNEL];
         words_sent <= ws_nxt;
      end
   end

   // take is a function of registered state only, so the fifo rd_en path has no loop through valid.
   always_comb begin
      state_nxt      = state;
      shift_nxt      = shift_q;
      cnt_nxt        = cnt_q;
      ws_nxt         = words_sent;
      take           = 1'b0;
      byte_out_valid = 1'b0;
      case (state)
         IDLE: begin
            take = 1'b1;
            if (valid) begin
               shift_nxt = data;
               cnt_nxt   = '0;
               state_nxt = SEND;
            end
         end
         SEND: begin
            byte_out_valid = ~full_q;
            if (!full_q) begin
               shift_nxt = {shift_q[WIDTH-9:0], 8'h00};
               cnt_nxt   = cnt_q + CW'(1);
               if (cnt_q == LAST) begin
                  take   = 1'b1;
                  ws_nxt = words_sent + CNT_WIDTH'(1);
                  if (valid) begin
                     shift_nxt = data;
                     cnt_nxt   = '0;
                  end else begin
                     state_nxt = IDLE;
                  end
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_singles_byte_serializer.sv
// Directed bench with a fifo model feeding the serializer and a byte scoreboard checked at negedge.
module tb_singles_byte_serializer;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         f_valid = 1'b0;
   logic         ready;
   logic [127:0] f_data = '0;
   logic [7:0]   channel_full = 8'h00;
   logic [7:0]   byte_out;
   logic         byte_out_valid;
   logic [2:0]   channel;
   logic [7:0]   words_sent;

   int checks = 0;
   int failures = 0;
   int hs_cnt = 0;
   int mon_cnt = 0;
   int exp_ws = 0;
   bit pend = 1'b0;
   logic [127:0] fq[$];
   logic [7:0]   sb[$];

   singles_byte_serializer #(.WIDTH(128), .NCHAN(8), .CHANNEL(0), .CNT_WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .valid(f_valid), .ready(ready), .data(f_data),
      .channel_full(channel_full), .byte_out(byte_out), .byte_out_valid(byte_out_valid),
      .channel(channel), .words_sent(words_sent)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] byte_of(input logic [127:0] w, input int b);
      return w[127-8*b -: 8];
   endfunction

   task automatic push_word(input logic [127:0] w);
      fq.push_back(w);
      for (int b = 0; b < 16; b++) sb.push_back(byte_of(w, b));
   endtask

   // Fifo model and byte monitor: a handshake seen mid-cycle pops the word after the next posedge.
   always @(negedge clk) begin
      logic [127:0] tmp;
      if (pend && fq.size() > 0) tmp = fq.pop_front();
      f_valid = (fq.size() > 0);
      f_data  = f_valid ? fq[0] : '0;
      pend    = f_valid && ready;
      if (pend) hs_cnt++;
      if (byte_out_valid) begin
         mon_cnt++;
         if (sb.size() == 0) chk("extra_byte", byte_out_valid, 1'b0);
         else chk("byte", byte_out, sb.pop_front());
      end
   end

   task automatic measure(input int cycles, output int nvld, output int first, output bit gap);
      bit ended;
      nvld = 0; first = -1; gap = 1'b0; ended = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk); #1;
         if (byte_out_valid) begin
            if (first < 0) first = i;
            if (ended) gap = 1'b1;
            nvld++;
         end else if (first >= 0) ended = 1'b1;
      end
   endtask

   task automatic wait_drain(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(posedge clk); #1;
         if (sb.size() == 0 && fq.size() == 0 && !byte_out_valid) ok = 1'b1;
      end
   endtask

   function automatic logic [127:0] rnd_word();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin
      int nvld, first, hs0, m0;
      bit gap, ok;
      logic [127:0] w;

      // Reset state
      #2 rst_n = 1'b0;
      #1;
      chk("rst_ready", ready, 1'b0);
      chk("rst_bvalid", byte_out_valid, 1'b0);
      chk("rst_byte", byte_out, 8'h00);
      chk("rst_ws", words_sent, 8'd0);
      chk("channel", channel, 3'd0);
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      // 1: single word, contiguous bytes
      hs0 = hs_cnt;
      push_word(128'h00112233_44556677_8899AABB_CCDDEEFF);
      measure(20, nvld, first, gap);
      exp_ws++;
      chk("t1_nvld", nvld, 16);
      chk("t1_first", first, 0);
      chk("t1_gap", gap, 1'b0);
      chk("t1_ws", words_sent, exp_ws[7:0]);
      chk("t1_hs", hs_cnt - hs0, 1);
      chk("t1_tc", channel, 3'd0);

      // 2: three back-to-back words
      hs0 = hs_cnt;
      for (int k = 0; k < 3; k++) push_word(rnd_word());
      measure(60, nvld, first, gap);
      exp_ws += 3;
      chk("t2_nvld", nvld, 48);
      chk("t2_first", first, 0);
      chk("t2_gap", gap, 1'b0);
      chk("t2_hs", hs_cnt - hs0, 3);
      chk("t2_ws", words_sent, exp_ws[7:0]);

      // 3: full asserted while byte 5 is on the bus, held 4 cycles
      w = rnd_word();
      m0 = mon_cnt;
      push_word(w);
      repeat (6) @(posedge clk);
      #1;
      chk("t3_b5", byte_out, byte_of(w, 5));
      chk("t3_b5_vld", byte_out_valid, 1'b1);
      channel_full = 8'h01;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         chk("t3_stall_vld", byte_out_valid, 1'b0);
      end
      channel_full = 8'h00;
      @(posedge clk); #1;
      chk("t3_b6_vld", byte_out_valid, 1'b1);
      chk("t3_b6", byte_out, byte_of(w, 6));
      wait_drain(40, ok);
      exp_ws++;
      chk("t3_drain", ok, 1'b1);
      chk("t3_count", mon_cnt - m0, 16);
      chk("t3_ws", words_sent, exp_ws[7:0]);

      // 4: other channels full, singles channel free
      channel_full = 8'hFE;
      push_word(rnd_word());
      measure(20, nvld, first, gap);
      exp_ws++;
      chk("t4_nvld", nvld, 16);
      chk("t4_first", first, 0);
      chk("t4_gap", gap, 1'b0);
      chk("t4_ws", words_sent, exp_ws[7:0]);
      channel_full = 8'h00;

      // 5: reset while byte 7 is on the bus
      w = rnd_word();
      push_word(w);
      repeat (8) @(posedge clk);
      #1;
      chk("t5_b7", byte_out, byte_of(w, 7));
      rst_n = 1'b0;
      #1;
      chk("t5_bvalid", byte_out_valid, 1'b0);
      chk("t5_ws", words_sent, 8'd0);
      chk("t5_ready", ready, 1'b0);
      sb.delete();
      exp_ws = 0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      push_word(128'hA0A1A2A3_A4A5A6A7_A8A9AAAB_ACADAEAF);
      measure(20, nvld, first, gap);
      exp_ws++;
      chk("t5_nvld", nvld, 16);
      chk("t5_first", first, 0);
      chk("t5_ws_after", words_sent, exp_ws[7:0]);

      // 6: 8-bit counter wrap
      rst_n = 1'b0;
      #2;
      sb.delete();
      exp_ws = 0;
      @(posedge clk);
      #3 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < 256; k++) push_word(rnd_word());
      wait_drain(5000, ok);
      chk("t6_drain", ok, 1'b1);
      chk("t6_ws256", words_sent, 8'd0);
      push_word(rnd_word());
      wait_drain(40, ok);
      chk("t6_drain2", ok, 1'b1);
      chk("t6_ws257", words_sent, 8'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
